// File: rtl/sevenseg_pkg.sv
// Shared definitions for the multiplexed seven-segment scanner: segment bit
// indices, display mode encoding, hex font and scan-slot length.
package sevenseg_pkg;

  localparam int unsigned SEG_A  = 0;
  localparam int unsigned SEG_B  = 1;
  localparam int unsigned SEG_C  = 2;
  localparam int unsigned SEG_D  = 3;
  localparam int unsigned SEG_E  = 4;
  localparam int unsigned SEG_F  = 5;
  localparam int unsigned SEG_G  = 6;
  localparam int unsigned SEG_DP = 7;

  typedef enum logic {
    MODE_RAW = 1'b0,
    MODE_HEX = 1'b1
  } seg_mode_e;

  function automatic logic [6:0] hex_font(input logic [3:0] nibble);
    logic [6:0] seg;
    case (nibble)
      4'h0:    seg = 7'h3F;
      4'h1:    seg = 7'h06;
      4'h2:    seg = 7'h5B;
      4'h3:    seg = 7'h4F;
      4'h4:    seg = 7'h66;
      4'h5:    seg = 7'h6D;
      4'h6:    seg = 7'h7D;
      4'h7:    seg = 7'h07;
      4'h8:    seg = 7'h7F;
      4'h9:    seg = 7'h6F;
      4'hA:    seg = 7'h77;
      4'hB:    seg = 7'h7C;
      4'hC:    seg = 7'h39;
      4'hD:    seg = 7'h5E;
      4'hE:    seg = 7'h79;
      default: seg = 7'h71;
    endcase
    return seg;
  endfunction

  // Clock cycles spent on each digit within one full refresh frame.
  function automatic int unsigned tick_cycles(input int unsigned clk_hz,
                                              input int unsigned rate_hz,
                                              input int unsigned digits);
    return clk_hz / (rate_hz * digits);
  endfunction

  function automatic int unsigned width_of(input int unsigned count);
    return (count > 1) ? $clog2(count) : 1;
  endfunction

endpackage

// File: rtl/sevenseg_hex_decoder.sv
// Combinational hex-nibble to seven-segment (a..g) decoder.
module sevenseg_hex_decoder
  import sevenseg_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] segments
);

  assign segments = hex_font(nibble);

endmodule

// File: rtl/sevenseg_scan.sv
// Multiplexed N-digit seven-segment driver with frame-latched updates, PWM
// dimming, blanking and dead time. Hex mode is built when SEVENSEG_HEX_DECODE_EN is defined.
module sevenseg_scan
  import sevenseg_pkg::*;
#(
  parameter int unsigned DIGITS     = 3,
  parameter int unsigned CLK_HZ     = 100000000,
  parameter int unsigned RATE_HZ    = 1000,
  parameter int unsigned PWM_BITS   = 4,
  parameter bit          ACTIVE_LOW = 1'b1
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  wr_en,
  input  logic [DIGITS*8-1:0]   wr_data,
  input  logic                  mode,
  input  logic [DIGITS-1:0]     blank,
  input  logic [PWM_BITS-1:0]   brightness,
  output logic [7:0]            ss,
  output logic [DIGITS-1:0]     ssen,
  output logic                  frame_tick
);

  localparam int unsigned TICK = tick_cycles(CLK_HZ, RATE_HZ, DIGITS);
  localparam int unsigned TW   = width_of(TICK);
  localparam int unsigned DW   = width_of(DIGITS);

  logic [TW-1:0]         tick_cnt;
  logic [DW-1:0]         digit;
  logic [PWM_BITS-1:0]   pwm_cnt;

  logic [DIGITS*8-1:0]   disp_data;
  logic [DIGITS-1:0]     disp_blank;
  logic [DIGITS*8-1:0]   pend_data;
  logic [DIGITS-1:0]     pend_blank;
  logic                  pend_vld;
  logic                  frame_tick_q;

  logic                  wrap;
  logic                  frame_end;
  logic                  commit;
  logic                  load_pend;

  logic [7:0]            cur_byte;
  logic                  cur_blank;
  logic [7:0]            pattern;
  logic                  lit;
  logic [DIGITS-1:0]     onehot;

  logic [7:0]            seg_q;
  logic [DIGITS-1:0]     en_q;

  // ---------------------------------------------------------------------------
  // Slot timing, digit scan and PWM phase
  // ---------------------------------------------------------------------------
  assign wrap      = (tick_cnt == TW'(TICK - 1));
  assign frame_end = wrap && (digit == DW'(DIGITS - 1));

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      tick_cnt <= '0;
      digit    <= '0;
      pwm_cnt  <= '0;
    end else begin
      pwm_cnt <= pwm_cnt + PWM_BITS'(1);
      if (wrap) begin
        tick_cnt <= '0;
        digit    <= frame_end ? '0 : digit + DW'(1);
      end else begin
        tick_cnt <= tick_cnt + TW'(1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Shadow registers: writes park in pending and are committed at frame end.
  // A write landing on the frame-end cycle bypasses pending.
  // ---------------------------------------------------------------------------
  assign commit    = frame_end && (wr_en || pend_vld);
  assign load_pend = wr_en && !commit;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      disp_data    <= '0;
      disp_blank   <= '0;
      pend_data    <= '0;
      pend_blank   <= '0;
      pend_vld     <= 1'b0;
      frame_tick_q <= 1'b0;
    end else begin
      frame_tick_q <= commit;
      if (commit) begin
        disp_data  <= wr_en ? wr_data : pend_data;
        disp_blank <= wr_en ? blank   : pend_blank;
        pend_vld   <= 1'b0;
      end else if (load_pend) begin
        pend_data  <= wr_data;
        pend_blank <= blank;
        pend_vld   <= 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Current digit selection
  // ---------------------------------------------------------------------------
  always_comb begin
    cur_byte  = '0;
    cur_blank = 1'b0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (digit == DW'(i)) begin
        cur_byte  = disp_data[i*8 +: 8];
        cur_blank = disp_blank[i];
      end
    end
  end

`ifdef SEVENSEG_HEX_DECODE_EN
  seg_mode_e  disp_mode;
  seg_mode_e  pend_mode;
  logic [6:0] font;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      disp_mode <= MODE_RAW;
      pend_mode <= MODE_RAW;
    end else if (commit) begin
      disp_mode <= wr_en ? seg_mode_e'(mode) : pend_mode;
    end else if (load_pend) begin
      pend_mode <= seg_mode_e'(mode);
    end
  end

  sevenseg_hex_decoder u_hex_decoder (
    .nibble   (cur_byte[3:0]),
    .segments (font)
  );

  assign pattern = (disp_mode == MODE_HEX) ? {cur_byte[SEG_DP], font} : cur_byte;
`else
  logic unused_mode;

  assign unused_mode = mode;
  assign pattern     = cur_byte;
`endif

  // ---------------------------------------------------------------------------
  // Output stage; slot cycle 0 is dead time so the previous digit never ghosts
  // ---------------------------------------------------------------------------
  assign lit    = (tick_cnt != '0) && (pwm_cnt <= brightness) && !cur_blank;
  assign onehot = DIGITS'(1) << digit;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      seg_q <= '0;
      en_q  <= '0;
    end else begin
      seg_q <= pattern;
      en_q  <= lit ? onehot : '0;
    end
  end

  assign ss         = ACTIVE_LOW ? ~seg_q : seg_q;
  assign ssen       = ACTIVE_LOW ? ~en_q  : en_q;
  assign frame_tick = frame_tick_q;

endmodule
